// File: rtl/regfile_pkg.sv
// Shared constants and the write-request record for the register-file write path.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward; ptr moves past
// the winner only when an enabled grant actually fires.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;

  // first requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    int idx;
    grant_s    = {NUM_REQ{1'b0}};
    found_s    = 1'b0;
    next_ptr_s = ptr_r;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (enable && request[idx] && !found_s) begin
        grant_s[idx] = 1'b1;
        found_s      = 1'b1;
        if (idx == NUM_REQ - 1) begin
          next_ptr_s = {PTR_W{1'b0}};
        end else begin
          next_ptr_s = PTR_W'(idx + 1);
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (found_s) begin
      ptr_r <= next_ptr_s;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and one-entry output stage for the register-file write port.
// Optional build macro: REGFILE_ZERO_PROTECT_EN (handshake but drop writes to register 0).
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  output logic                          write_enable,
  output logic [ADDR_WIDTH-1:0]         write_address,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          pending_valid,
  output logic [ADDR_WIDTH-1:0]         pending_address
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t             stg_r;
  logic               stg_valid_r;
  stage_t             win_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic               load_s;

  // reset gating keeps a staged write from reaching the register file on the reset edge
  assign accept_s = (~stg_valid_r | ~hold) & ~reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .enable  (accept_s),
    .request (req_valid),
    .grant   (grant_s)
  );

  // one-hot grant selects the winning address/data
  always_comb begin
    win_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        win_s.address = win_s.address | req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_s.data    = win_s.data    | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        win_s = win_s;
      end
    end
  end

`ifdef REGFILE_ZERO_PROTECT_EN
  assign load_s = (|grant_s) && (win_s.address != {ADDR_WIDTH{1'b0}});
`else
  assign load_s = |grant_s;
`endif

  // output stage: refills whenever it may accept, holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_r <= 1'b0;
      stg_r       <= '0;
    end else if (accept_s) begin
      stg_valid_r <= load_s;
      if (load_s) begin
        stg_r <= win_s;
      end
    end
  end

  assign req_ready       = grant_s;
  assign write_enable    = stg_valid_r & ~hold & ~reset;
  assign write_address   = stg_r.address;
  assign write_data      = stg_r.data;
  assign pending_valid   = stg_valid_r;
  assign pending_address = stg_r.address;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter with a register-file model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NR = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NR-1:0]            req_valid = '0;
  logic [NR*ADDR_WIDTH-1:0] req_address = '0;
  logic [NR*DATA_WIDTH-1:0] req_data = '0;
  logic [NR-1:0]            req_ready;
  logic                     hold = 1'b0;
  logic                     write_enable;
  logic [ADDR_WIDTH-1:0]    write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     pending_valid;
  logic [ADDR_WIDTH-1:0]    pending_address;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS] = '{default: 32'h0};

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_arbiter #(.NUM_REQ(NR)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_address     (req_address),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .hold            (hold),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .pending_valid   (pending_valid),
    .pending_address (pending_address)
  );

  always #5 clk = ~clk;

  // register-file model driven by the DUT write port
  always @(posedge clk) begin
    if (write_enable === 1'b1) regs[write_address] <= write_data;
  end

  typedef struct {
    logic        rst;
    logic        hold;
    logic [3:0]  valid;
    logic [19:0] addr;
    logic [3:0]  ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pv;
    logic [4:0]  paddr;
  } vec_t;

  vec_t tbl[$];

  localparam logic [19:0] AD  = {5'd7, 5'd6, 5'd5, 5'd4};
  localparam logic [19:0] A3  = {5'd7, 5'd6, 5'd5, 5'd3};
  localparam logic [19:0] A9  = {5'd7, 5'd6, 5'd9, 5'd4};
  localparam logic [19:0] A12 = {5'd7, 5'd12, 5'd9, 5'd4};
  localparam logic [19:0] A0  = {5'd7, 5'd6, 5'd5, 5'd0};

  function automatic vec_t mk(logic rst, logic hd, logic [3:0] vl, logic [19:0] ad,
                              logic [3:0] rdy, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic pv, logic [4:0] pa);
    vec_t v;
    v.rst = rst; v.hold = hd; v.valid = vl; v.addr = ad; v.ready = rdy;
    v.we = we; v.waddr = wa; v.wdata = wd; v.pv = pv; v.paddr = pa;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // rst hold valid addr | ready we waddr wdata pv paddr
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, AD,  4'b0000, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0001, A3,  4'b0001, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd3, 32'hA5,  1'b1, 5'd3));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, AD,  4'b0000, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b0001, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b0010, 1'b1, 5'd4, 32'hA6,  1'b1, 5'd4));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b0100, 1'b1, 5'd5, 32'hA7,  1'b1, 5'd5));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b1000, 1'b1, 5'd6, 32'hA8,  1'b1, 5'd6));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b0001, 1'b1, 5'd7, 32'hA9,  1'b1, 5'd7));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd4, 32'hA6,  1'b1, 5'd4));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0010, A9,  4'b0010, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0100, A12, 4'b0000, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0100, A12, 4'b0000, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0100, A12, 4'b0000, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0100, A12, 4'b0100, 1'b1, 5'd9, 32'hAB,  1'b1, 5'd9));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, AD,  4'b0000, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, AD,  4'b0001, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd4, 32'hA6,  1'b1, 5'd4));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0110, AD,  4'b0010, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1000, AD,  4'b1000, 1'b1, 5'd5, 32'hA7,  1'b1, 5'd5));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd7, 32'hA9,  1'b1, 5'd7));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0001, AD,  4'b0001, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0010, AD,  4'b0000, 1'b0, 5'd0, 32'h0,   1'b1, 5'd4));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd4, 32'hA6,  1'b1, 5'd4));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0001, A0,  4'b0001, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
`ifdef REGFILE_ZERO_PROTECT_EN
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0));
`else
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, AD,  4'b0000, 1'b1, 5'd0, 32'hA2,  1'b1, 5'd0));
`endif

    repeat (2) @(negedge clk);
    chk("reset_pending_valid", {31'h0, pending_valid}, 32'h0);
    chk("reset_write_enable", {31'h0, write_enable}, 32'h0);

    foreach (tbl[r]) begin
      @(negedge clk);
      reset     = tbl[r].rst;
      hold      = tbl[r].hold;
      req_valid = tbl[r].valid;
      for (int i = 0; i < NR; i++) begin
        req_address[i*ADDR_WIDTH +: ADDR_WIDTH] = tbl[r].addr[i*5 +: 5];
        req_data[i*DATA_WIDTH +: DATA_WIDTH]    = 32'hA2 + 32'(tbl[r].addr[i*5 +: 5]);
      end
      #1;
      chk($sformatf("row%0d_req_ready", r), {28'h0, req_ready}, {28'h0, tbl[r].ready});
      chk($sformatf("row%0d_write_enable", r), {31'h0, write_enable}, {31'h0, tbl[r].we});
      if (!tbl[r].rst) begin
        chk($sformatf("row%0d_pending_valid", r), {31'h0, pending_valid}, {31'h0, tbl[r].pv});
        if (tbl[r].we) begin
          chk($sformatf("row%0d_write_address", r), {27'h0, write_address}, {27'h0, tbl[r].waddr});
          chk($sformatf("row%0d_write_data", r), write_data, tbl[r].wdata);
        end
        if (tbl[r].pv) begin
          chk($sformatf("row%0d_pending_address", r), {27'h0, pending_address}, {27'h0, tbl[r].paddr});
        end
      end
    end

    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("reg3", regs[3], 32'hA5);
    chk("reg4", regs[4], 32'hA6);
    chk("reg5", regs[5], 32'hA7);
    chk("reg6", regs[6], 32'hA8);
    chk("reg7", regs[7], 32'hA9);
    chk("reg9", regs[9], 32'hAB);
    chk("reg12_discarded_by_reset", regs[12], 32'h0);
`ifdef REGFILE_ZERO_PROTECT_EN
    chk("reg0_protected", regs[0], 32'h0);
`else
    chk("reg0_written", regs[0], 32'hA2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
